fmc_adc_idelay_seq: RTL and testbench
=====================================

// Module: fmc_adc_idelay_seq
// PURPOSE
//  Sequences IDELAY tap loads into the four ltcInterface ADC channels from one host command port.
//  Per command: waits for the channel's delay_rdy, pulses delay_load, waits for settling, then reads back and verifies the tap.
//  Broadcast mode applies one tap/select pair to ADC0..ADC3 in order.
//  Sits between the host register bank (sys_clk domain) and the adcN_delay_* ports of fmc_adc_130m_4ch.
// PARAMETERS
//  SETTLE_CYCLES   8     sys_clk cycles from load pulse to readback sample (1..255)
//  TIMEOUT_CYCLES  1024  max sys_clk cycles waiting for delay_rdy; used only when IDELAY_SEQ_TIMEOUT_EN is defined
// PORTS
//  sys_clk             in   1   system clock; all logic on its rising edge
//  rst                 in   1   asynchronous, active-high reset
//  cmd_valid           in   1   command request
//  cmd_ready           out  1   command accepted when cmd_valid & cmd_ready
//  cmd_chan            in   2   target ADC (ignored when cmd_bcast=1)
//  cmd_bcast           in   1   1 = apply to ADC0..3 sequentially
//  cmd_tap             in   5   IDELAY tap value
//  cmd_sel             in   17  line mask: [15:0] data lines, [16] overrange line
//  rsp_valid           out  1   response available; held until rsp_ready
//  rsp_ready           in   1   response consumed
//  rsp_err             out  2   [0] rdy timeout, [1] readback mismatch (OR over all channels of a broadcast)
//  rsp_chan            out  2   first failing channel; else last channel processed
//  rsp_tap_read        out  5   readback of last channel processed
//  busy                out  1   high from accept until response consumed
//  adc_delay_reg       out  20  tap to ADCn at [5n+4:5n]
//  adc_delay_select    out  68  mask to ADCn at [17n+16:17n]
//  adc_delay_load      out  4   one-cycle load pulse, bit n -> ADCn
//  adc_delay_rdy       in   4   ADCn delay_rdy (level)
//  adc_delay_reg_read  in   20  ADCn tap readback at [5n+4:5n]
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FSM -> IDLE; counters 0. Mid-operation reset drops load immediately; no response is issued.
//  Inputs are synchronous to sys_clk; no synchronisers here.
//  FSM states: IDLE, WAIT_RDY, LOAD, SETTLE, CHECK, RESP.
//  IDLE: cmd_ready=1. On accept, latch tap/sel/chan/bcast; ch = bcast ? 0 : cmd_chan; clear err -> WAIT_RDY. cmd_ready=0 outside IDLE.
//  WAIT_RDY: if cmd_sel==0 -> CHECK (no load, no compare). Else when adc_delay_rdy[ch]=1 -> LOAD.
//  LOAD (1 cycle): drive adc_delay_reg/select slice ch = latched tap/sel (registered, same cycle as load); adc_delay_load[ch]=1 -> SETTLE.
//    Slices keep their last driven value until that channel is loaded again; other slices are untouched.
//  SETTLE: count SETTLE_CYCLES cycles -> CHECK.
//  CHECK (1 cycle): capture slice ch of adc_delay_reg_read into rsp_tap_read; if loaded and readback!=tap, set err[1].
//    On the first error, record ch in rsp_chan.
//    If bcast & ch<3: ch<=ch+1 -> WAIT_RDY; else -> RESP.
//  RESP: rsp_valid=1 with stable rsp_*; on rsp_ready -> IDLE, busy=0. New cmd accepted no earlier than the next cycle.
//  Latency, single channel with rdy already high: accept -> load pulse 2 cycles; load -> rsp_valid SETTLE_CYCLES+2 cycles.
//  At most one bit of adc_delay_load is high in any cycle; it is never high two cycles in a row.
//  rsp_chan: if no error, equals last ch processed (3 for broadcast).
//  cmd_valid while busy: ignored (held by host, not dropped by spec: accepted on return to IDLE).
// CONFIGURATION
//  IDELAY_SEQ_TIMEOUT_EN defined: WAIT_RDY counts cycles. After TIMEOUT_CYCLES without rdy, set err[0], record rsp_chan if first error, skip LOAD/SETTLE.
//    Go to CHECK: readback captured, no compare. Broadcast then continues with the next channel.
//  Not defined: WAIT_RDY waits indefinitely; rsp_err[0] is constant 0; no timeout counter is synthesised.
// TESTING
//  1 Reset asserted mid-SETTLE -> adc_delay_load=0, rsp_valid=0, cmd_ready=1 immediately; all delay outputs 0.
//  2 chan=2, tap=13, sel=0x1FFFF, rdy=4'hF, readback echoes -> one load pulse on bit 2 only.
//    adc_delay_reg[14:10]=13; rsp_err=00, rsp_chan=2, rsp_tap_read=13 after SETTLE_CYCLES+2.
//  3 bcast, tap=7, sel=0x0FFFF, ADC1 readback forced to 6 -> loads on bits 0,1,2,3 in order; rsp_err=10, rsp_chan=1.
//  4 chan=0, sel=0 -> no load pulse; rsp_err=00; rsp_tap_read = current ADC0 readback.
//  5 (TIMEOUT_EN) chan=3, rdy[3]=0 held -> rsp_err=01, rsp_chan=3 after TIMEOUT_CYCLES; no load. Without the macro: busy stays 1.
//    Raising rdy[3] then gives a load and rsp_err=00.
//  6 rsp_ready held 0 for 20 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0.
//    After rsp_ready, the next cmd is accepted the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/fmc_adc_idelay_seq_if.sv
// Host command/response port of the IDELAY load sequencer.
// master = host register bank side, slave = sequencer side.
interface fmc_adc_idelay_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_chan;
  logic        cmd_bcast;
  logic [4:0]  cmd_tap;
  logic [16:0] cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_err;
  logic [1:0]  rsp_chan;
  logic [4:0]  rsp_tap_read;

  modport master (
    output cmd_valid, cmd_chan, cmd_bcast, cmd_tap, cmd_sel, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_chan, rsp_tap_read
  );

  modport slave (
    input  cmd_valid, cmd_chan, cmd_bcast, cmd_tap, cmd_sel, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_chan, rsp_tap_read
  );
endinterface

// File: rtl/fmc_adc_idelay_seq.sv
// Sequences IDELAY tap loads into the four ADC channels from one host command port.
// Define IDELAY_SEQ_TIMEOUT_EN to bound the wait on delay_rdy by TIMEOUT_CYCLES.
module fmc_adc_idelay_seq #(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  fmc_adc_idelay_seq_if.slave        host,
  output logic                       busy,
  output logic [19:0]                adc_delay_reg,
  output logic [67:0]                adc_delay_select,
  output logic [3:0]                 adc_delay_load,
  input  logic [3:0]                 adc_delay_rdy,
  input  logic [19:0]                adc_delay_reg_read
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned TAP_W = 5;
  localparam int unsigned SEL_W = 17;
  localparam int unsigned SET_W = 8;
`ifdef IDELAY_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
`endif

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fmc_adc_idelay_seq: SETTLE_CYCLES must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_RESP
  } state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   ch_q, ch_d;
  logic                         bcast_q, bcast_d;
  logic [TAP_W-1:0]             tap_q, tap_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic                         loaded_q, loaded_d;
  logic [SET_W-1:0]             set_cnt_q, set_cnt_d;
  logic [1:0]                   err_q, err_d;
  logic [1:0]                   rsp_chan_q, rsp_chan_d;
  logic [TAP_W-1:0]             rsp_tap_q, rsp_tap_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic                         cmd_ready_q, cmd_ready_d;
  logic                         busy_q, busy_d;
  logic [NCH-1:0][TAP_W-1:0]    dly_reg_q, dly_reg_d;
  logic [NCH-1:0][SEL_W-1:0]    dly_sel_q, dly_sel_d;
  logic [NCH-1:0]               load_q, load_d;
  logic [NCH-1:0][TAP_W-1:0]    rd_tap;
`ifdef IDELAY_SEQ_TIMEOUT_EN
  logic [TO_W-1:0]              to_cnt_q, to_cnt_d;
`endif

  assign rd_tap = adc_delay_reg_read;

  // Next-state and next-output logic for the load/settle/check sequence
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    bcast_d     = bcast_q;
    tap_d       = tap_q;
    sel_d       = sel_q;
    loaded_d    = loaded_q;
    set_cnt_d   = set_cnt_q;
    err_d       = err_q;
    rsp_chan_d  = rsp_chan_q;
    rsp_tap_d   = rsp_tap_q;
    rsp_valid_d = rsp_valid_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    dly_reg_d   = dly_reg_q;
    dly_sel_d   = dly_sel_q;
    load_d      = '0;
`ifdef IDELAY_SEQ_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (host.cmd_valid && cmd_ready_q) begin
          tap_d       = host.cmd_tap;
          sel_d       = host.cmd_sel;
          bcast_d     = host.cmd_bcast;
          ch_d        = host.cmd_bcast ? 2'd0 : host.cmd_chan;
          err_d       = '0;
          loaded_d    = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_WAIT_RDY;
`ifdef IDELAY_SEQ_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end

      S_WAIT_RDY: begin
        if (sel_q == '0) begin
          state_d = S_CHECK;
        end else if (adc_delay_rdy[ch_q]) begin
          // Slice and load pulse become visible together in the LOAD cycle
          dly_reg_d[ch_q] = tap_q;
          dly_sel_d[ch_q] = sel_q;
          load_d[ch_q]    = 1'b1;
          loaded_d        = 1'b1;
          state_d         = S_LOAD;
        end
`ifdef IDELAY_SEQ_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d[0] = 1'b1;
          if (err_q == '0) begin
            rsp_chan_d = ch_q;
          end
          state_d = S_CHECK;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      S_LOAD: begin
        set_cnt_d = '0;
        state_d   = S_SETTLE;
      end

      S_SETTLE: begin
        if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_CHECK;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end

      S_CHECK: begin
        rsp_tap_d = rd_tap[ch_q];
        if (loaded_q && (rd_tap[ch_q] != tap_q)) begin
          err_d[1] = 1'b1;
        end
        // With no earlier error this tracks the last channel, or latches the first failure
        if (err_q == '0) begin
          rsp_chan_d = ch_q;
        end
        loaded_d = 1'b0;
`ifdef IDELAY_SEQ_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        if (bcast_q && (ch_q != 2'd3)) begin
          ch_d    = ch_q + 2'd1;
          state_d = S_WAIT_RDY;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any load in flight without a response
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      bcast_q     <= 1'b0;
      tap_q       <= '0;
      sel_q       <= '0;
      loaded_q    <= 1'b0;
      set_cnt_q   <= '0;
      err_q       <= '0;
      rsp_chan_q  <= '0;
      rsp_tap_q   <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      dly_reg_q   <= '0;
      dly_sel_q   <= '0;
      load_q      <= '0;
`ifdef IDELAY_SEQ_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      bcast_q     <= bcast_d;
      tap_q       <= tap_d;
      sel_q       <= sel_d;
      loaded_q    <= loaded_d;
      set_cnt_q   <= set_cnt_d;
      err_q       <= err_d;
      rsp_chan_q  <= rsp_chan_d;
      rsp_tap_q   <= rsp_tap_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      dly_reg_q   <= dly_reg_d;
      dly_sel_q   <= dly_sel_d;
      load_q      <= load_d;
`ifdef IDELAY_SEQ_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign host.cmd_ready    = cmd_ready_q;
  assign host.rsp_valid    = rsp_valid_q;
  assign host.rsp_err      = err_q;
  assign host.rsp_chan     = rsp_chan_q;
  assign host.rsp_tap_read = rsp_tap_q;
  assign busy              = busy_q;
  assign adc_delay_reg     = dly_reg_q;
  assign adc_delay_select  = dly_sel_q;
  assign adc_delay_load    = load_q;

endmodule

// File: tb/tb_fmc_adc_idelay_seq.sv
// Randomized self-checking bench for fmc_adc_idelay_seq with an emulated ADC bank
// and a command-level reference model of taps, readbacks and responses.
module tb_fmc_adc_idelay_seq;
  localparam int unsigned S = 8;
  localparam int unsigned T = 1024;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  fmc_adc_idelay_seq_if bus();
  logic                busy;
  logic [3:0][4:0]     adc_reg;
  logic [3:0][16:0]    adc_sel;
  logic [3:0]          adc_load;
  logic [3:0]          adc_rdy;
  logic [3:0][4:0]     rb;

  fmc_adc_idelay_seq #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .sys_clk            (sys_clk),
    .rst                (rst),
    .host               (bus),
    .busy               (busy),
    .adc_delay_reg      (adc_reg),
    .adc_delay_select   (adc_sel),
    .adc_delay_load     (adc_load),
    .adc_delay_rdy      (adc_rdy),
    .adc_delay_reg_read (rb)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Emulated ADC bank: a load latches the driven tap, optionally corrupted
  logic [3:0]          corrupt_en;
  logic [3:0][4:0]     corrupt_val;
  logic                seed_rb;
  logic [3:0][4:0]     seed_val;
  always @(posedge sys_clk) begin
    if (seed_rb) rb <= seed_val;
    else for (int n = 0; n < 4; n++)
      if (adc_load[n]) rb[n] <= corrupt_en[n] ? corrupt_val[n] : adc_reg[n];
  end

  // Load pulse log plus one-hot / no back-to-back checks
  typedef struct packed { int c; logic [3:0] bits; } ld_t;
  ld_t load_log[$];
  logic [3:0] prev_load = '0;
  always @(negedge sys_clk) begin
    if (rst) prev_load = '0;
    else begin
      if (adc_load != '0) begin
        total++;
        if (!$onehot(adc_load) || prev_load != '0) begin
          bad++;
          $display("FAIL load_pulse got=%b prev=%b required=onehot after zero", adc_load, prev_load);
        end
        load_log.push_back('{c: cyc, bits: adc_load});
      end
      prev_load = adc_load;
    end
  end

  // Reference model state: what each ADC slice / readback should hold
  logic [3:0][4:0]  m_reg, m_rb;
  logic [3:0][16:0] m_sel;
  typedef struct packed {
    logic [1:0] err; logic [1:0] chan; logic [4:0] tap_read;
    logic [2:0] nload; logic [3:0][1:0] order;
  } exp_t;

  function automatic exp_t model_cmd(input logic [1:0] ch, input logic bc,
                                     input logic [4:0] tp, input logic [16:0] sl);
    exp_t e;
    int first = -1;
    int last = 0;
    int lo = bc ? 0 : int'(ch);
    int hi = bc ? 3 : int'(ch);
    e = '0;
    for (int c = lo; c <= hi; c++) begin
      if (sl != '0) begin
        m_reg[c] = tp;
        m_sel[c] = sl;
        m_rb[c]  = corrupt_en[c] ? corrupt_val[c] : tp;
        e.order[e.nload] = 2'(c);
        e.nload++;
        if (m_rb[c] != tp && first < 0) first = c;
      end
      last = c;
      e.tap_read = m_rb[c];
    end
    e.err  = (first >= 0) ? 2'b10 : 2'b00;
    e.chan = (first >= 0) ? 2'(first) : 2'(last);
    return e;
  endfunction

  function automatic logic [10:0] obs_loads();
    logic [2:0] n = 3'(load_log.size() > 7 ? 7 : load_log.size());
    logic [3:0][1:0] o = '0;
    for (int i = 0; i < load_log.size() && i < 4; i++)
      for (int b = 0; b < 4; b++)
        if (load_log[i].bits[b]) o[i] = 2'(b);
    return {n, o};
  endfunction

  task automatic issue_cmd(input logic [1:0] ch, input logic bc, input logic [4:0] tp,
                           input logic [16:0] sl, output int acc, output bit ok);
    ok = 0; acc = -1;
    bus.cmd_chan = ch; bus.cmd_bcast = bc; bus.cmd_tap = tp; bus.cmd_sel = sl;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (bus.cmd_ready) begin @(negedge sys_clk); acc = cyc; ok = 1; break; end
      @(negedge sys_clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int lim, output int rc, output bit ok);
    ok = 0; rc = -1;
    for (int i = 0; i < lim; i++) begin
      if (bus.rsp_valid) begin ok = 1; rc = cyc; break; end
      @(negedge sys_clk);
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(negedge sys_clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    m_reg = '0; m_sel = '0;
    rst = 1'b0;
    load_log.delete();
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    int acc; bit ok; logic [4:0] tp;
    total++;
    if ({adc_load, bus.rsp_valid, bus.cmd_ready, busy, bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read, adc_reg, adc_sel}
        !== {4'b0, 1'b0, 1'b1, 1'b0, 2'b0, 2'b0, 5'b0, 20'b0, 68'b0}) begin
      bad++; $display("FAIL reset_state got ready=%b valid=%b busy=%b required ready=1 others=0",
                      bus.cmd_ready, bus.rsp_valid, busy);
    end
    tp = 5'($urandom);
    issue_cmd(2'd1, 1'b0, tp, 17'h1FFFF, acc, ok);
    void'(model_cmd(2'd1, 1'b0, tp, 17'h1FFFF));
    for (int i = 0; i < 20 && load_log.size() == 0; i++) @(negedge sys_clk);
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    #1;
    total++;
    if (!ok || {adc_load, bus.rsp_valid, bus.cmd_ready, busy, adc_reg, adc_sel}
        !== {4'b0, 1'b0, 1'b1, 1'b0, 20'b0, 68'b0}) begin
      bad++; $display("FAIL reset_mid_settle got load=%b valid=%b ready=%b busy=%b reg=%h required 0/0/1/0/0",
                      adc_load, bus.rsp_valid, bus.cmd_ready, busy, adc_reg);
    end
    @(negedge sys_clk);
    do_reset();
  endtask

  task automatic test_single();
    int acc, rc; bit ok1, ok2; exp_t e;
    load_log.delete();
    e = model_cmd(2'd2, 1'b0, 5'd13, 17'h1FFFF);
    issue_cmd(2'd2, 1'b0, 5'd13, 17'h1FFFF, acc, ok1);
    wait_rsp(100, rc, ok2);
    total++;
    if (!ok1 || !ok2 || {bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read} !== {e.err, e.chan, e.tap_read}) begin
      bad++; $display("FAIL single_rsp got err=%b chan=%0d tap=%0d required err=00 chan=2 tap=13",
                      bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read);
    end
    total++;
    if (obs_loads() !== {e.nload, e.order} || load_log.size() != 1 ||
        load_log[0].c != acc + 1 || rc != load_log[0].c + int'(S) + 2) begin
      bad++; $display("FAIL single_timing got loads=%h acc=%0d rsp=%0d required one load on bit2 at acc+1, rsp at load+%0d",
                      obs_loads(), acc, rc, S + 2);
    end
    total++;
    if (adc_reg[2] !== 5'd13 || adc_reg !== m_reg || adc_sel !== m_sel) begin
      bad++; $display("FAIL single_slices got reg=%h sel=%h required reg=%h sel=%h", adc_reg, adc_sel, m_reg, m_sel);
    end
    consume();
  endtask

  task automatic test_bcast();
    int acc, rc; bit ok1, ok2; exp_t e;
    load_log.delete();
    corrupt_en = 4'b0010; corrupt_val = '0; corrupt_val[1] = 5'd6;
    e = model_cmd(2'd3, 1'b1, 5'd7, 17'h0FFFF);
    issue_cmd(2'd3, 1'b1, 5'd7, 17'h0FFFF, acc, ok1);
    wait_rsp(200, rc, ok2);
    total++;
    if (!ok1 || !ok2 || {bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read} !== {2'b10, 2'd1, 5'd7}) begin
      bad++; $display("FAIL bcast_rsp got err=%b chan=%0d tap=%0d required err=10 chan=1 tap=7",
                      bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read);
    end
    total++;
    if (obs_loads() !== {e.nload, e.order} || adc_reg !== m_reg || adc_sel !== m_sel) begin
      bad++; $display("FAIL bcast_loads got loads=%h required=%h", obs_loads(), {e.nload, e.order});
    end
    corrupt_en = '0;
    consume();
  endtask

  task automatic test_sel_zero();
    int acc, rc; bit ok1, ok2; exp_t e;
    load_log.delete();
    e = model_cmd(2'd0, 1'b0, 5'($urandom), 17'h0);
    issue_cmd(2'd0, 1'b0, 5'd21, 17'h0, acc, ok1);
    wait_rsp(50, rc, ok2);
    total++;
    if (!ok1 || !ok2 || load_log.size() != 0 ||
        {bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read} !== {2'b00, 2'd0, e.tap_read}) begin
      bad++; $display("FAIL sel_zero got err=%b chan=%0d tap=%0d loads=%0d required err=00 chan=0 tap=%0d loads=0",
                      bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read, load_log.size(), e.tap_read);
    end
    consume();
  endtask

  task automatic test_rdy_wait();
    int acc, rc, rc0; bit ok1, ok2; exp_t e; logic [4:0] tp;
    load_log.delete();
    tp = 5'($urandom);
    adc_rdy = 4'b0111;
`ifdef IDELAY_SEQ_TIMEOUT_EN
    issue_cmd(2'd3, 1'b0, tp, 17'h1FFFF, acc, ok1);
    wait_rsp(T + 50, rc, ok2);
    total++;
    if (!ok1 || !ok2 || rc != acc + int'(T) + 1 || load_log.size() != 0 ||
        {bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read} !== {2'b01, 2'd3, m_rb[3]}) begin
      bad++; $display("FAIL rdy_timeout got err=%b chan=%0d tap=%0d dt=%0d required err=01 chan=3 tap=%0d dt=%0d",
                      bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read, rc - acc, m_rb[3], T + 1);
    end
    consume();
    adc_rdy = 4'hF;
    e = model_cmd(2'd3, 1'b0, tp, 17'h1FFFF);
    issue_cmd(2'd3, 1'b0, tp, 17'h1FFFF, acc, ok1);
    wait_rsp(100, rc, ok2);
    rc0 = acc + 1;
`else
    begin
      int viol = 0;
      issue_cmd(2'd3, 1'b0, tp, 17'h1FFFF, acc, ok1);
      for (int i = 0; i < 60; i++) begin
        if (!busy || bus.rsp_valid) viol++;
        @(negedge sys_clk);
      end
      total++;
      if (!ok1 || viol != 0 || load_log.size() != 0) begin
        bad++; $display("FAIL rdy_hold got viol=%0d loads=%0d required busy held, no rsp, no load", viol, load_log.size());
      end
      e = model_cmd(2'd3, 1'b0, tp, 17'h1FFFF);
      adc_rdy = 4'hF;
      rc0 = cyc + 1;
      wait_rsp(100, rc, ok2);
    end
`endif
    total++;
    if (!ok1 || !ok2 || load_log.size() != 1 || load_log[0].c != rc0 ||
        {bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read} !== {e.err, e.chan, e.tap_read}) begin
      bad++; $display("FAIL rdy_release got err=%b chan=%0d tap=%0d loads=%0d required err=%b chan=3 tap=%0d loads=1 at %0d",
                      bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read, load_log.size(), e.err, e.tap_read, rc0);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int acc, rc, viol; bit ok1, ok2; exp_t e1, e2; logic [4:0] t1, t2;
    load_log.delete();
    t1 = 5'($urandom); t2 = 5'($urandom);
    e1 = model_cmd(2'd1, 1'b0, t1, 17'h00F0F);
    issue_cmd(2'd1, 1'b0, t1, 17'h00F0F, acc, ok1);
    wait_rsp(100, rc, ok2);
    bus.cmd_chan = 2'd0; bus.cmd_bcast = 1'b0; bus.cmd_tap = t2; bus.cmd_sel = 17'h10001;
    bus.cmd_valid = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (!bus.rsp_valid || bus.cmd_ready ||
          {bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read} !== {e1.err, e1.chan, e1.tap_read}) viol++;
    end
    total++;
    if (!ok1 || !ok2 || viol != 0) begin
      bad++; $display("FAIL rsp_hold got viol=%0d required rsp stable, cmd_ready=0 for 20 cycles", viol);
    end
    e2 = model_cmd(2'd0, 1'b0, t2, 17'h10001);
    load_log.delete();
    consume();
    total++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL idle_return got ready=%b busy=%b valid=%b required 1/0/0", bus.cmd_ready, busy, bus.rsp_valid);
    end
    @(negedge sys_clk);
    acc = cyc;
    bus.cmd_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      bad++; $display("FAIL next_accept got busy=%b ready=%b required 1/0", busy, bus.cmd_ready);
    end
    wait_rsp(100, rc, ok2);
    total++;
    if (!ok2 || load_log.size() != 1 || load_log[0].c != acc + 1 ||
        {bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read} !== {e2.err, e2.chan, e2.tap_read}) begin
      bad++; $display("FAIL second_cmd got err=%b chan=%0d tap=%0d required err=%b chan=%0d tap=%0d",
                      bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read, e2.err, e2.chan, e2.tap_read);
    end
    consume();
  endtask

  task automatic test_random();
    int acc, rc; bit ok1, ok2; exp_t e;
    logic [1:0] ch; logic bc; logic [4:0] tp; logic [16:0] sl;
    for (int k = 0; k < 30; k++) begin
      load_log.delete();
      ch = 2'($urandom); bc = ($urandom_range(0, 2) == 0); tp = 5'($urandom);
      sl = ($urandom_range(0, 5) == 0) ? 17'h0 : 17'($urandom);
      if (sl == '0 && k % 2 == 0) sl = 17'h1;
      for (int n = 0; n < 4; n++) begin
        corrupt_en[n]  = ($urandom_range(0, 3) == 0);
        corrupt_val[n] = 5'($urandom);
      end
      e = model_cmd(ch, bc, tp, sl);
      issue_cmd(ch, bc, tp, sl, acc, ok1);
      wait_rsp(300, rc, ok2);
      total++;
      if (!ok1 || !ok2 || {bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read} !== {e.err, e.chan, e.tap_read}) begin
        bad++; $display("FAIL random_rsp[%0d] got err=%b chan=%0d tap=%0d required err=%b chan=%0d tap=%0d",
                        k, bus.rsp_err, bus.rsp_chan, bus.rsp_tap_read, e.err, e.chan, e.tap_read);
      end
      total++;
      if (obs_loads() !== {e.nload, e.order} || adc_reg !== m_reg || adc_sel !== m_sel) begin
        bad++; $display("FAIL random_loads[%0d] got loads=%h reg=%h required loads=%h reg=%h",
                        k, obs_loads(), adc_reg, {e.nload, e.order}, m_reg);
      end
      consume();
    end
    corrupt_en = '0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_chan = '0; bus.cmd_bcast = 1'b0;
    bus.cmd_tap = '0; bus.cmd_sel = '0; bus.rsp_ready = 1'b0;
    adc_rdy = 4'hF; corrupt_en = '0; corrupt_val = '0;
    for (int n = 0; n < 4; n++) seed_val[n] = 5'($urandom);
    m_rb = seed_val; m_reg = '0; m_sel = '0;
    seed_rb = 1'b1;
    repeat (3) @(negedge sys_clk);
    seed_rb = 1'b0;
    rst = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_single();
    test_bcast();
    test_sel_zero();
    test_rdy_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1);
  end
endmodule
